// File: rtl/cmp_pkg.sv
// Shared types and helpers for the shared-comparator arbiter.
package cmp_pkg;

   // Default operand width of the shared comparator datapath.
   localparam int unsigned CMP_W = 16;

   // One-hot comparison result.
   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_flags_t;

   // Round-robin successor of idx among n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 1 >= n) begin
         return 0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator built as an MSB-first greater/less propagate chain.
module mag_cmp #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq,
   output logic             o_lt
);

   logic w_gt;
   logic w_lt;

   // Walk from the MSB; the first differing bit decides and locks the chain.
   always_comb begin
      w_gt = 1'b0;
      w_lt = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (!w_gt && !w_lt) begin
            w_gt = i_a[i] & ~i_b[i];
            w_lt = ~i_a[i] & i_b[i];
         end
      end
   end

   assign o_gt = w_gt;
   assign o_lt = w_lt;
   assign o_eq = ~w_gt & ~w_lt;

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among N_REQ requesters,
// with a single registered response slot that honours backpressure.
module cmp_share_arbiter
   import cmp_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   parameter  int unsigned WIDTH = CMP_W,
   localparam int unsigned IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic                   rsp_gt,
   output logic                   rsp_eq,
   output logic                   rsp_lt,
   output logic [15:0]            op_count
);

   logic [IDW-1:0] r_rr;
   logic           r_rsp_valid;
   logic [IDW-1:0] r_rsp_id;
   cmp_flags_t     r_flags;
   logic [15:0]    r_op_count;

   logic           w_slot_free;
   logic           w_found;
   logic           w_accept;
   logic [IDW-1:0] w_win_idx;
   logic [IDW-1:0] w_rr_next;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   cmp_flags_t     w_flags;

   assign w_slot_free = !r_rsp_valid || rsp_ready;

   // Scan requesters from the rr pointer upward with wrap; first valid wins.
   always_comb begin
      int unsigned idx;
      w_found   = 1'b0;
      w_win_idx = '0;
      idx       = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = int'(r_rr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!w_found && req_valid[idx]) begin
            w_found   = 1'b1;
            w_win_idx = IDW'(idx);
         end
      end
   end

   // Reset also blocks grants so nothing looks accepted while the block is cleared.
   assign w_accept = w_found && w_slot_free && !rst;

   // One-hot grant to the winner only when the response slot can take it.
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_win_idx] = 1'b1;
      end
   end

   assign w_a       = req_a[w_win_idx*WIDTH +: WIDTH];
   assign w_b       = req_b[w_win_idx*WIDTH +: WIDTH];
   assign w_rr_next = IDW'(rr_next(int'(w_win_idx), N_REQ));

   mag_cmp #(
      .WIDTH(WIDTH)
   ) u_mag_cmp (
      .i_a (w_a),
      .i_b (w_b),
      .o_gt(w_flags.gt),
      .o_eq(w_flags.eq),
      .o_lt(w_flags.lt)
   );

   // Response slot, rr pointer and saturating operation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_flags     <= '0;
         r_op_count  <= '0;
      end else if (w_accept) begin
         // A draining response is replaced in the same edge.
         r_rr        <= w_rr_next;
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= w_win_idx;
         r_flags     <= w_flags;
         if (r_op_count != 16'hFFFF) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end else if (rsp_ready) begin
         // Flags and id hold their last values once the slot empties.
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_gt    = r_flags.gt;
   assign rsp_eq    = r_flags.eq;
   assign rsp_lt    = r_flags.lt;
   assign op_count  = r_op_count;

endmodule
